// File: rtl/w_io_pkg.sv
// Shared constants for the west-edge IO tile: per-channel config bit layout
// and the output-enable turnaround state encoding.
package w_io_pkg;

    localparam int unsigned CFG_W    = 4;
    localparam int unsigned CFG_IREG = 0;
    localparam int unsigned CFG_OREG = 1;
    localparam int unsigned CFG_SYNC = 2;
    localparam int unsigned CFG_TINV = 3;

    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        TURN  = 2'd1,
        DRIVE = 2'd2
    } turn_state_t;

endpackage

// File: rtl/w_io_chan.sv
// One pad channel: input synchroniser and register, optional output register,
// and the HIZ->TURN->DRIVE turnaround FSM that gates the pad output enable.
module w_io_chan
    import w_io_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CFG_W-1:0] i_cfg,
    input  logic             i_pad_o,
    output logic             o_pad_i,
    output logic             o_pad_t,
    output logic             o_fab_o,
    input  logic             i_fab_i,
    input  logic             i_fab_t,
    output logic             o_turn_busy
);

    localparam int unsigned CW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_ireg;
    logic          r_oi;
    logic          r_ot;
    turn_state_t   r_state;
    logic [CW-1:0] r_cnt;

    logic w_sync_out;
    logic w_treq_raw;
    logic w_treq;

    assign w_sync_out = i_cfg[CFG_SYNC] ? r_sync2 : i_pad_o;
    assign o_fab_o    = i_cfg[CFG_IREG] ? r_ireg  : w_sync_out;

    assign w_treq_raw = i_fab_t ^ i_cfg[CFG_TINV];
    assign w_treq     = i_cfg[CFG_OREG] ? r_ot : w_treq_raw;
    assign o_pad_i    = i_cfg[CFG_OREG] ? r_oi : i_fab_i;

    assign o_pad_t     = (r_state != DRIVE);
    assign o_turn_busy = (r_state == TURN);

    // Data flops run regardless of config so a config change never flushes them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_ireg  <= 1'b0;
            r_oi    <= 1'b0;
            r_ot    <= 1'b0;
        end else begin
            r_sync1 <= i_pad_o;
            r_sync2 <= r_sync1;
            r_ireg  <= w_sync_out;
            r_oi    <= i_fab_i;
            r_ot    <= w_treq_raw;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= HIZ;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                HIZ: begin
                    if (!w_treq) begin
                        if (TURN_CYCLES == 0) begin
                            r_state <= DRIVE;
                        end else begin
                            r_state <= TURN;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                TURN: begin
                    if (w_treq) begin
                        r_state <= HIZ;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        r_state <= DRIVE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DRIVE: begin
                    if (w_treq) begin
                        r_state <= HIZ;
                    end
                end
                default: begin
                    r_state <= HIZ;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/w_io_n_chan.sv
// Parametrised west-edge IO tile: NUM_CH independent pad channels plus
// combinational passthroughs of clock, config and frame signals.
module w_io_n_chan
    import w_io_pkg::*;
#(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned TURN_CYCLES     = 2,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20
) (
    input  logic                        UserCLK,
    input  logic                        UserRST,
    output logic                        UserCLKo,
    input  logic [NUM_CH*CFG_W-1:0]     ConfigBits,
    output logic [NUM_CH*CFG_W-1:0]     Config_C,
    input  logic [NUM_CH-1:0]           PAD_O,
    output logic [NUM_CH-1:0]           PAD_I,
    output logic [NUM_CH-1:0]           PAD_T,
    output logic [NUM_CH-1:0]           FAB_O,
    input  logic [NUM_CH-1:0]           FAB_I,
    input  logic [NUM_CH-1:0]           FAB_T,
    output logic [NUM_CH-1:0]           TURN_BUSY,
    input  logic [FrameBitsPerRow-1:0]  FrameData,
    output logic [FrameBitsPerRow-1:0]  FrameData_O,
    input  logic [MaxFramesPerCol-1:0]  FrameStrobe,
    output logic [MaxFramesPerCol-1:0]  FrameStrobe_O
);

    assign UserCLKo      = UserCLK;
    assign Config_C      = ConfigBits;
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = FrameStrobe;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        w_io_chan #(
            .TURN_CYCLES(TURN_CYCLES)
        ) u_chan (
            .i_clk       (UserCLK),
            .i_rst       (UserRST),
            .i_cfg       (ConfigBits[c*CFG_W +: CFG_W]),
            .i_pad_o     (PAD_O[c]),
            .o_pad_i     (PAD_I[c]),
            .o_pad_t     (PAD_T[c]),
            .o_fab_o     (FAB_O[c]),
            .i_fab_i     (FAB_I[c]),
            .i_fab_t     (FAB_T[c]),
            .o_turn_busy (TURN_BUSY[c])
        );
    end

endmodule

// File: tb/tb_w_io_n_chan.sv
// Directed bench for w_io_n_chan: 4-channel tile with TURN_CYCLES=2 and a
// 1-channel tile with TURN_CYCLES=0 sharing clock and reset.
module tb_w_io_n_chan;

    logic        clk;
    logic        rst;

    logic        clko;
    logic [15:0] cfg;
    logic [15:0] cfg_c;
    logic [3:0]  pad_o, pad_i, pad_t, fab_o, fab_i, fab_t, busy;
    logic [31:0] fdata, fdata_o;
    logic [19:0] fstrb, fstrb_o;

    logic        z_clko;
    logic [3:0]  z_cfg, z_cfg_c;
    logic [0:0]  z_pad_o, z_pad_i, z_pad_t, z_fab_o, z_fab_i, z_fab_t, z_busy;
    logic [31:0] z_fdata_o;
    logic [19:0] z_fstrb_o;

    int checks   = 0;
    int failures = 0;

    w_io_n_chan #(
        .NUM_CH(4), .TURN_CYCLES(2), .FrameBitsPerRow(32), .MaxFramesPerCol(20)
    ) dut (
        .UserCLK(clk), .UserRST(rst), .UserCLKo(clko),
        .ConfigBits(cfg), .Config_C(cfg_c),
        .PAD_O(pad_o), .PAD_I(pad_i), .PAD_T(pad_t), .FAB_O(fab_o),
        .FAB_I(fab_i), .FAB_T(fab_t), .TURN_BUSY(busy),
        .FrameData(fdata), .FrameData_O(fdata_o),
        .FrameStrobe(fstrb), .FrameStrobe_O(fstrb_o)
    );

    w_io_n_chan #(
        .NUM_CH(1), .TURN_CYCLES(0), .FrameBitsPerRow(32), .MaxFramesPerCol(20)
    ) dut0 (
        .UserCLK(clk), .UserRST(rst), .UserCLKo(z_clko),
        .ConfigBits(z_cfg), .Config_C(z_cfg_c),
        .PAD_O(z_pad_o), .PAD_I(z_pad_i), .PAD_T(z_pad_t), .FAB_O(z_fab_o),
        .FAB_I(z_fab_i), .FAB_T(z_fab_t), .TURN_BUSY(z_busy),
        .FrameData(fdata), .FrameData_O(z_fdata_o),
        .FrameStrobe(fstrb), .FrameStrobe_O(z_fstrb_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fab_t = 4'h0; fab_i = 4'h0; cfg = 16'h0400; pad_o = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pad_t !== 4'hF) begin failures++; $display("FAIL reset_pad_t cyc=%0d got=%h exp=%h", i, pad_t, 4'hF); end
            checks++; if (pad_i !== 4'h0) begin failures++; $display("FAIL reset_pad_i cyc=%0d got=%h exp=%h", i, pad_i, 4'h0); end
            checks++; if (busy !== 4'h0) begin failures++; $display("FAIL reset_busy cyc=%0d got=%h exp=%h", i, busy, 4'h0); end
            checks++; if (fab_o !== 4'b1011) begin failures++; $display("FAIL reset_fab_o cyc=%0d got=%b exp=%b", i, fab_o, 4'b1011); end
            checks++; if (z_pad_t !== 1'b1) begin failures++; $display("FAIL reset_z_pad_t cyc=%0d got=%b exp=1", i, z_pad_t); end
        end
        rst = 1'b0;
        step();
        checks++; if (pad_t !== 4'hF || busy !== 4'hF) begin failures++; $display("FAIL rel_e1 pad_t=%h busy=%h exp F F", pad_t, busy); end
        step();
        checks++; if (pad_t !== 4'hF || busy !== 4'hF) begin failures++; $display("FAIL rel_e2 pad_t=%h busy=%h exp F F", pad_t, busy); end
        step();
        checks++; if (pad_t !== 4'h0 || busy !== 4'h0) begin failures++; $display("FAIL rel_e3 pad_t=%h busy=%h exp 0 0", pad_t, busy); end
        fab_t = 4'hF; cfg = 16'h0000; pad_o = 4'h0;
        step();
        checks++; if (pad_t !== 4'hF) begin failures++; $display("FAIL rel_release pad_t=%h exp F", pad_t); end
    endtask

    task automatic test_latency();
        logic [3:0] lcfg [3] = '{4'b0001, 4'b0100, 4'b0101};
        int         lexp [3] = '{1, 2, 3};
        for (int t = 0; t < 3; t++) begin
            cfg[3:0] = lcfg[t];
            pad_o = 4'h0;
            for (int i = 0; i < 4; i++) step();
            pad_o[0] = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                step();
                if (k == 1) pad_o[0] = 1'b0;
                checks++;
                if (fab_o[0] !== (k == lexp[t])) begin
                    failures++;
                    $display("FAIL latency cfg=%b edge=%0d got=%b exp=%b", lcfg[t], k, fab_o[0], (k == lexp[t]));
                end
            end
        end
        cfg[3:0] = 4'b0000;
        pad_o[0] = 1'b1; #1;
        checks++; if (fab_o[0] !== 1'b1) begin failures++; $display("FAIL latency_comb_hi got=%b exp=1", fab_o[0]); end
        pad_o[0] = 1'b0; #1;
        checks++; if (fab_o[0] !== 1'b0) begin failures++; $display("FAIL latency_comb_lo got=%b exp=0", fab_o[0]); end
    endtask

    task automatic test_turnaround();
        fab_t[0] = 1'b0;
        step();
        checks++; if (busy[0] !== 1'b1 || pad_t[0] !== 1'b1) begin failures++; $display("FAIL turn_e1 busy=%b pad_t=%b exp 1 1", busy[0], pad_t[0]); end
        step();
        checks++; if (busy[0] !== 1'b1 || pad_t[0] !== 1'b1) begin failures++; $display("FAIL turn_e2 busy=%b pad_t=%b exp 1 1", busy[0], pad_t[0]); end
        step();
        checks++; if (busy[0] !== 1'b0 || pad_t[0] !== 1'b0) begin failures++; $display("FAIL turn_e3 busy=%b pad_t=%b exp 0 0", busy[0], pad_t[0]); end
        fab_t[0] = 1'b1;
        step();
        checks++; if (pad_t[0] !== 1'b1) begin failures++; $display("FAIL release got=%b exp=1", pad_t[0]); end

        cfg[3:0] = 4'b0010;
        step();
        fab_t[0] = 1'b0; fab_i[0] = 1'b1; #1;
        checks++; if (pad_i[0] !== 1'b0) begin failures++; $display("FAIL oreg_pad_i_pre got=%b exp=0", pad_i[0]); end
        step();
        checks++; if (pad_i[0] !== 1'b1) begin failures++; $display("FAIL oreg_pad_i_post got=%b exp=1", pad_i[0]); end
        checks++; if (busy[0] !== 1'b0 || pad_t[0] !== 1'b1) begin failures++; $display("FAIL oreg_e1 busy=%b pad_t=%b exp 0 1", busy[0], pad_t[0]); end
        step();
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL oreg_e2 busy=%b exp 1", busy[0]); end
        step();
        checks++; if (busy[0] !== 1'b1 || pad_t[0] !== 1'b1) begin failures++; $display("FAIL oreg_e3 busy=%b pad_t=%b exp 1 1", busy[0], pad_t[0]); end
        step();
        checks++; if (pad_t[0] !== 1'b0) begin failures++; $display("FAIL oreg_e4 pad_t=%b exp 0", pad_t[0]); end
        fab_t[0] = 1'b1;
        step();
        checks++; if (pad_t[0] !== 1'b0) begin failures++; $display("FAIL oreg_rel_e1 pad_t=%b exp 0", pad_t[0]); end
        step();
        checks++; if (pad_t[0] !== 1'b1) begin failures++; $display("FAIL oreg_rel_e2 pad_t=%b exp 1", pad_t[0]); end
        cfg[3:0] = 4'b0000; fab_i[0] = 1'b0;
        step();
    endtask

    task automatic test_abort();
        fab_t[0] = 1'b0;
        step();
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL abort_turn busy=%b exp 1", busy[0]); end
        fab_t[0] = 1'b1;
        step();
        checks++; if (busy[0] !== 1'b0 || pad_t[0] !== 1'b1) begin failures++; $display("FAIL abort_hiz busy=%b pad_t=%b exp 0 1", busy[0], pad_t[0]); end
        step();
        checks++; if (pad_t[0] !== 1'b1) begin failures++; $display("FAIL abort_stay pad_t=%b exp 1", pad_t[0]); end
        fab_t[0] = 1'b0;
        step();
        step();
        checks++; if (busy[0] !== 1'b1 || pad_t[0] !== 1'b1) begin failures++; $display("FAIL abort_full_e2 busy=%b pad_t=%b exp 1 1", busy[0], pad_t[0]); end
        step();
        checks++; if (pad_t[0] !== 1'b0) begin failures++; $display("FAIL abort_full_e3 pad_t=%b exp 0", pad_t[0]); end
        fab_t[0] = 1'b1;
        step();
    endtask

    task automatic test_tinv();
        cfg[7:4] = 4'b1000;
        step();
        checks++; if (busy[1] !== 1'b1) begin failures++; $display("FAIL tinv_e1 busy=%b exp 1", busy[1]); end
        step();
        step();
        checks++; if (pad_t[1] !== 1'b0) begin failures++; $display("FAIL tinv_e3 pad_t=%b exp 0", pad_t[1]); end
        fab_t[1] = 1'b0;
        step();
        checks++; if (pad_t[1] !== 1'b1) begin failures++; $display("FAIL tinv_release pad_t=%b exp 1", pad_t[1]); end
        fab_t[1] = 1'b1; cfg[7:4] = 4'b0000;
        step();
        checks++; if (pad_t[1] !== 1'b1 || busy[1] !== 1'b0) begin failures++; $display("FAIL tinv_restore pad_t=%b busy=%b exp 1 0", pad_t[1], busy[1]); end
    endtask

    task automatic test_turn0();
        z_fab_t = 1'b0; #1;
        checks++; if (z_pad_t !== 1'b1) begin failures++; $display("FAIL t0_pre pad_t=%b exp 1", z_pad_t); end
        step();
        checks++; if (z_pad_t !== 1'b0 || z_busy !== 1'b0) begin failures++; $display("FAIL t0_drive pad_t=%b busy=%b exp 0 0", z_pad_t, z_busy); end
        z_fab_t = 1'b1;
        step();
        checks++; if (z_pad_t !== 1'b1) begin failures++; $display("FAIL t0_release pad_t=%b exp 1", z_pad_t); end
    endtask

    task automatic test_independence();
        logic [3:0] exp_t [4] = '{4'b1111, 4'b1111, 4'b1101, 4'b0101};
        logic [3:0] exp_b [4] = '{4'b0010, 4'b1010, 4'b1000, 4'b0000};
        fab_t[1] = 1'b0;
        for (int e = 0; e < 4; e++) begin
            step();
            if (e == 0) fab_t[3] = 1'b0;
            checks++;
            if (pad_t !== exp_t[e] || busy !== exp_b[e]) begin
                failures++;
                $display("FAIL indep_e%0d pad_t=%b busy=%b exp %b %b", e + 1, pad_t, busy, exp_t[e], exp_b[e]);
            end
        end
        rst = 1'b1;
        step();
        checks++; if (pad_t !== 4'hF || busy !== 4'h0) begin failures++; $display("FAIL mid_drive_reset pad_t=%h busy=%h exp F 0", pad_t, busy); end
        step();
        checks++; if (pad_t !== 4'hF) begin failures++; $display("FAIL reset_dominates pad_t=%h exp F", pad_t); end
        rst = 1'b0; fab_t = 4'hF;
        step();
    endtask

    task automatic test_passthrough();
        fdata = 32'hA5C3_0F1E; fstrb = 20'h5A5A3; cfg = 16'hBEEF; z_cfg = 4'h9; #1;
        checks++; if (fdata_o !== 32'hA5C3_0F1E) begin failures++; $display("FAIL pt_framedata got=%h exp=%h", fdata_o, 32'hA5C3_0F1E); end
        checks++; if (fstrb_o !== 20'h5A5A3) begin failures++; $display("FAIL pt_framestrobe got=%h exp=%h", fstrb_o, 20'h5A5A3); end
        checks++; if (cfg_c !== 16'hBEEF) begin failures++; $display("FAIL pt_config got=%h exp=%h", cfg_c, 16'hBEEF); end
        checks++; if (z_cfg_c !== 4'h9 || z_fdata_o !== 32'hA5C3_0F1E) begin failures++; $display("FAIL pt_dut0 cfg=%h fd=%h", z_cfg_c, z_fdata_o); end
        step();
        checks++; if (clko !== 1'b1 || z_clko !== 1'b1) begin failures++; $display("FAIL pt_clk_hi got=%b%b exp=11", clko, z_clko); end
        #5;
        checks++; if (clko !== 1'b0) begin failures++; $display("FAIL pt_clk_lo got=%b exp=0", clko); end
    endtask

    initial begin
        rst = 1'b1; cfg = '0; pad_o = '0; fab_i = '0; fab_t = '0;
        fdata = '0; fstrb = '0;
        z_cfg = '0; z_pad_o = '0; z_fab_i = '0; z_fab_t = 1'b1;
        #2;
        test_reset();
        test_latency();
        test_turnaround();
        test_abort();
        test_tinv();
        test_turn0();
        test_independence();
        test_passthrough();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
